// File: rtl/level_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// level_sensor_conditioner
//
// Turns the two raw float switches of the high tank into the clean level
// pair used by the electrovalve controller. Each switch is synchronised and
// debounced. The debounced pair is then checked for the impossible
// combination "above 90 % but below 5 %". If that combination persists, a
// sensor fault is latched and the "tank full" code (1/1) is forced, so the
// valve closes.
//
// Optional build macro: LEVEL_GLITCH_CNT_EN
//   Adds output glitchCnt, a saturating count of rejected switch transitions.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed to accept a new switch level (>=2)
//   FAULT_CYCLES    : cycles an invalid pair must persist to latch a fault (>=2)
//   CNT_W           : timer width, must hold max(DEBOUNCE_CYCLES, FAULT_CYCLES)
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   rawLow      in   raw 5 % switch, asynchronous (1 = water above 5 %)
//   rawHigh     in   raw 90 % switch, asynchronous (1 = water above 90 %)
//   clrFault    in   one-cycle pulse clearing a latched fault
//   lowLevel    out  conditioned 5 % level
//   highLevel   out  conditioned 90 % level
//   levelValid  out  1 once the start-up debounce window has completed
//   sensorFault out  latched invalid-sensor indication
//   glitchCnt   out  [7:0] rejected-transition count (LEVEL_GLITCH_CNT_EN only)
// ---------------------------------------------------------------------------
module level_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FAULT_CYCLES    = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rawLow,
    input  logic       rawHigh,
    input  logic       clrFault,
    output logic       lowLevel,
    output logic       highLevel,
    output logic       levelValid,
    output logic       sensorFault
`ifdef LEVEL_GLITCH_CNT_EN
    ,
    output logic [7:0] glitchCnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLT_LAST   = CNT_W'(FAULT_CYCLES - 1);
    // levelValid rises on the edge after the counter has seen D+1 cycles,
    // i.e. at cycle DEBOUNCE_CYCLES+2 after reset release.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    // Channel index 0 = low switch, 1 = high switch.
    logic [1:0]       meta;
    logic [1:0]       synced;
    logic [1:0]       stable;
    logic [CNT_W-1:0] deb_cnt [2];
    logic [CNT_W-1:0] startup_cnt;
    logic [CNT_W-1:0] fault_timer;
    logic [1:0]       last_valid;   // {high, low} of the most recent valid pair
    state_t           state;
    logic             pair_invalid;

    // ---------------- two-flop synchroniser ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 2'b00;
            synced <= 2'b00;
        end else begin
            meta   <= {rawHigh, rawLow};
            synced <= meta;
        end
    end

    // ---------------- start-up window ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            startup_cnt <= '0;
            levelValid  <= 1'b0;
        end else if (!levelValid) begin
            if (startup_cnt == START_LAST) begin
                levelValid <= 1'b1;
            end else begin
                startup_cnt <= startup_cnt + CNT_ONE;
            end
        end
    end

    // ---------------- per-channel debounce ----------------
    // During start-up the stable level simply tracks the synced input so the
    // first valid pair reflects the real tank state without extra delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable     <= 2'b11;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!levelValid) begin
                    stable[i]  <= synced[i];
                    deb_cnt[i] <= '0;
                end else if (synced[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stable[i]  <= synced[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign pair_invalid = stable[1] & ~stable[0];

    // ---------------- plausibility FSM with registered outputs ----------------
    // Outputs are written in the same branch that decides the next state, so
    // they always agree with the state being entered (no one-cycle leak of an
    // invalid pair when moving OK -> SUSPECT).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OK;
            fault_timer <= '0;
            last_valid  <= 2'b11;
            sensorFault <= 1'b0;
            lowLevel    <= 1'b1;
            highLevel   <= 1'b1;
        end else begin
            if (!pair_invalid) begin
                last_valid <= stable;
            end

            if (!levelValid) begin
                state       <= ST_OK;
                fault_timer <= '0;
                sensorFault <= 1'b0;
                lowLevel    <= 1'b1;
                highLevel   <= 1'b1;
            end else begin
                case (state)
                    ST_OK: begin
                        if (pair_invalid) begin
                            state       <= ST_SUSPECT;
                            fault_timer <= '0;
                            lowLevel    <= last_valid[0];
                            highLevel   <= last_valid[1];
                        end else begin
                            lowLevel    <= stable[0];
                            highLevel   <= stable[1];
                        end
                    end
                    ST_SUSPECT: begin
                        if (!pair_invalid) begin
                            state       <= ST_OK;
                            lowLevel    <= stable[0];
                            highLevel   <= stable[1];
                        end else if (fault_timer == FLT_LAST) begin
                            state       <= ST_FAULT;
                            sensorFault <= 1'b1;
                            lowLevel    <= 1'b1;
                            highLevel   <= 1'b1;
                        end else begin
                            fault_timer <= fault_timer + CNT_ONE;
                            lowLevel    <= last_valid[0];
                            highLevel   <= last_valid[1];
                        end
                    end
                    ST_FAULT: begin
                        // Clearing needs a plausible pair; otherwise stay latched.
                        if (clrFault && !pair_invalid) begin
                            state       <= ST_OK;
                            sensorFault <= 1'b0;
                            lowLevel    <= stable[0];
                            highLevel   <= stable[1];
                        end else begin
                            sensorFault <= 1'b1;
                            lowLevel    <= 1'b1;
                            highLevel   <= 1'b1;
                        end
                    end
                    default: begin
                        state       <= ST_FAULT;
                        sensorFault <= 1'b1;
                        lowLevel    <= 1'b1;
                        highLevel   <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef LEVEL_GLITCH_CNT_EN
    // ---------------- rejected-transition counter ----------------
    // A rejection is a debounce counter falling back to zero from a nonzero
    // value because the synced input re-agreed with the stable level.
    logic [1:0] reject;
    logic [8:0] glitch_sum;
    logic [7:0] glitch_cnt;

    always_comb begin
        reject = 2'b00;
        for (int i = 0; i < 2; i++) begin
            reject[i] = levelValid && (synced[i] == stable[i]) && (deb_cnt[i] != '0);
        end
        glitch_sum = {1'b0, glitch_cnt} + {8'd0, reject[0]} + {8'd0, reject[1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= 8'd0;
        end else if (clrFault) begin
            glitch_cnt <= 8'd0;
        end else if (glitch_sum[8]) begin
            glitch_cnt <= 8'hFF;
        end else begin
            glitch_cnt <= glitch_sum[7:0];
        end
    end

    assign glitchCnt = glitch_cnt;
`endif

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Testbench for level_sensor_conditioner with DEBOUNCE_CYCLES=4, FAULT_CYCLES=8.
// Stimulus pushes expected output snapshots tagged with the cycle they must
// hold on; a monitor on the falling edge pops and compares them.
module tb_level_sensor_conditioner;

    localparam int DEB = 4;
    localparam int FLT = 8;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic rawLow   = 1'b0;
    logic rawHigh  = 1'b0;
    logic clrFault = 1'b0;
    logic lowLevel, highLevel, levelValid, sensorFault;
`ifdef LEVEL_GLITCH_CNT_EN
    logic [7:0] glitchCnt;
`endif

    level_sensor_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .FAULT_CYCLES   (FLT),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rawLow     (rawLow),
        .rawHigh    (rawHigh),
        .clrFault   (clrFault),
        .lowLevel   (lowLevel),
        .highLevel  (highLevel),
        .levelValid (levelValid),
        .sensorFault(sensorFault)
`ifdef LEVEL_GLITCH_CNT_EN
        ,
        .glitchCnt  (glitchCnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] exp;   // {lowLevel, highLevel, levelValid, sensorFault}
        int         gl;    // expected glitchCnt, -1 = not checked
        string      name;
    } exp_t;

    exp_t sbq[$];
    exp_t keep_q[$];
    int checks = 0;
    int errors = 0;

    task automatic expect_at(input int off, input logic l, input logic h,
                             input logic v, input logic f, input int gl,
                             input string name);
        exp_t e;
        e.cyc  = cyc + off;
        e.exp  = {l, h, v, f};
        e.gl   = gl;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic expect_out(input int off, input logic l, input logic h,
                              input logic v, input logic f, input string name);
        expect_at(off, l, h, v, f, -1, name);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        keep_q = {};
        foreach (sbq[i]) begin
            if (sbq[i].cyc == cyc) begin
                checks++;
                if ({lowLevel, highLevel, levelValid, sensorFault} !== sbq[i].exp) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): low/high/valid/fault got %b required %b",
                             sbq[i].name, cyc,
                             {lowLevel, highLevel, levelValid, sensorFault}, sbq[i].exp);
                end
`ifdef LEVEL_GLITCH_CNT_EN
                if (sbq[i].gl >= 0) begin
                    checks++;
                    if (glitchCnt !== 8'(sbq[i].gl)) begin
                        errors++;
                        $display("FAIL %s glitchCnt (cycle %0d): got %0d required %0d",
                                 sbq[i].name, cyc, glitchCnt, sbq[i].gl);
                    end
                end
`endif
            end else if (sbq[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never compared", sbq[i].name, sbq[i].cyc);
            end else begin
                keep_q.push_back(sbq[i]);
            end
        end
        sbq = keep_q;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with rawLow=1, rawHigh=0 (water between 5 % and 90 %)
        rst_n = 1'b0; rawLow = 1'b1; rawHigh = 1'b0; clrFault = 1'b0;
        step(1);
        expect_out(0, 1, 1, 0, 0, "reset_state");
        step(2);

        // Start-up window
        rst_n = 1'b1;
        expect_out(0, 1, 1, 0, 0, "startup_c0");
        expect_out(3, 1, 1, 0, 0, "startup_c3");
        expect_out(5, 1, 1, 0, 0, "startup_c5");
        expect_out(6, 1, 1, 1, 0, "valid_c6");
        expect_out(7, 1, 0, 1, 0, "pair_c7");
        step(10);

        // Persistent low edge: lowLevel falls 2+4+1 cycles later
        expect_out(6, 1, 0, 1, 0, "deb_fall_c6");
        expect_out(7, 0, 0, 1, 0, "deb_fall_c7");
        rawLow = 1'b0;
        step(10);
        expect_out(7, 1, 0, 1, 0, "deb_rise_c7");
        rawLow = 1'b1;
        step(10);

        // 3-cycle low pulse is rejected
        expect_out(3, 1, 0, 1, 0, "pulse_c3");
        expect_out(6, 1, 0, 1, 0, "pulse_c6");
        expect_at (9, 1, 0, 1, 0, 1, "pulse_reject_c9");
        rawLow = 1'b0;
        step(3);
        rawLow = 1'b1;
        step(10);

        // Short invalid pair: SUSPECT holds last valid pair, no fault
        expect_out(6,  1, 0, 1, 0, "suspect_c6");
        expect_out(7,  1, 0, 1, 0, "suspect_c7");
        expect_out(9,  1, 0, 1, 0, "suspect_c9");
        expect_out(11, 1, 0, 1, 0, "suspect_c11");
        expect_out(12, 1, 0, 1, 0, "suspect_c12");
        expect_out(14, 1, 0, 1, 0, "suspect_c14");
        rawLow = 1'b0; rawHigh = 1'b1;
        step(5);
        rawLow = 1'b1; rawHigh = 1'b0;
        step(12);

        // Persistent invalid pair: fault after SUSPECT entry + 8
        expect_out(14, 1, 0, 1, 0, "pre_fault");
        expect_out(15, 1, 1, 1, 1, "fault_latch");
        rawLow = 1'b0; rawHigh = 1'b1;
        step(18);

        // clrFault while still invalid is ignored
        expect_out(0, 1, 1, 1, 1, "fault_before_clr");
        expect_out(2, 1, 1, 1, 1, "clr_ignored_c2");
        expect_out(4, 1, 1, 1, 1, "clr_ignored_c4");
        clrFault = 1'b1;
        step(1);
        clrFault = 1'b0;
        step(5);

        // Valid 0/0 restored: fault stays latched
        expect_out(8, 1, 1, 1, 1, "fault_held_valid");
        rawHigh = 1'b0;
        step(10);

        // clrFault with valid pair: OK and 0/0 next cycle
        expect_out(0, 1, 1, 1, 1, "pre_clr");
        expect_out(1, 0, 0, 1, 0, "clr_ok");
        expect_out(3, 0, 0, 1, 0, "clr_ok_c3");
        clrFault = 1'b1;
        step(1);
        clrFault = 1'b0;
        step(4);

        // Fault again, then asynchronous reset in FAULT
        expect_out(16, 1, 1, 1, 1, "fault_again");
        rawHigh = 1'b1;
        step(20);
        #1;
        rst_n = 1'b0;
        expect_out(0, 1, 1, 0, 0, "async_reset");
        expect_out(2, 1, 1, 0, 0, "in_reset");
        rawLow = 1'b0; rawHigh = 1'b0;
        step(3);
        rst_n = 1'b1;
        expect_out(5, 1, 1, 0, 0, "restart_c5");
        expect_out(6, 1, 1, 1, 0, "restart_c6");
        expect_out(7, 0, 0, 1, 0, "restart_c7");
        step(12);

        // Both switches rise together: one new pair, no SUSPECT
        expect_out(6,  0, 0, 1, 0, "both_rise_c6");
        expect_out(7,  1, 1, 1, 0, "both_rise_c7");
        expect_out(8,  1, 1, 1, 0, "both_rise_c8");
        expect_out(12, 1, 1, 1, 0, "both_rise_c12");
        rawLow = 1'b1; rawHigh = 1'b1;
        step(14);

        for (int k = 0; k < 50 && sbq.size() > 0; k++) step(1);
        if (sbq.size() > 0) begin
            checks += sbq.size();
            errors += sbq.size();
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
